// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the signals exchanged between the pipeline datapath and the hazard
// controller: ID/EX operand descriptors, the redirect, the data-memory
// handshake and the per-stage stall/flush/bubble controls.
//   master : pipeline datapath side (describes instructions, obeys controls)
//   slave  : hazard controller side (observes instructions, issues controls)
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    // ID-stage source operands
    logic [REG_ADDR_W-1:0] id_rs1_addr_i;
    logic [REG_ADDR_W-1:0] id_rs2_addr_i;
    logic                  id_rs1_used_i;
    logic                  id_rs2_used_i;

    // EX-stage instruction
    logic                  ex_valid_i;
    logic                  ex_mem_ren_i;
    logic [REG_ADDR_W-1:0] ex_rd_addr_i;
    logic                  ex_redirect_i;

    // Data-memory handshake
    logic                  mem_access_i;
    logic                  dmem_ready_i;
    logic                  dmem_req_o;

    // Pipeline register controls
    logic                  pc_stall_o;
    logic                  ifid_stall_o;
    logic                  idex_stall_o;
    logic                  exmem_stall_o;
    logic                  ifid_flush_o;
    logic                  idex_flush_o;
    logic                  memwb_bubble_o;
    logic                  bus_err_o;

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
        output ex_valid_i, ex_mem_ren_i, ex_rd_addr_i, ex_redirect_i,
        output mem_access_i, dmem_ready_i,
        input  dmem_req_o,
        input  pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
        input  ifid_flush_o, idex_flush_o, memwb_bubble_o, bus_err_o
    );

    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
        input  ex_valid_i, ex_mem_ren_i, ex_rd_addr_i, ex_redirect_i,
        input  mem_access_i, dmem_ready_i,
        output dmem_req_o,
        output pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
        output ifid_flush_o, idex_flush_o, memwb_bubble_o, bus_err_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard controller for a 5-stage in-order pipeline. Tracks outstanding
// data-memory accesses with a RUN/WAIT/ERR FSM and a bounded wait counter,
// and turns memory waits, taken redirects and load-use dependencies into
// stall, flush and bubble controls with priority
//   ERR > memory stall > redirect > load-use.
// A redirect that coincides with a memory stall is not lost: EX is held, so
// ex_redirect_i is still asserted in the cycle the access completes.
//
// Optional feature: define PIPE_PERF_CNT_EN to add three free-running 32-bit
// performance counters (load-use stall, memory stall and redirect flush
// cycles) as extra output ports.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipeline_hazard_ctrl_if.slave bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]           perf_lu_stall_o,
    output logic [31:0]           perf_mem_stall_o,
    output logic [31:0]           perf_flush_o
`endif
);

    // Wide enough to hold WAIT_TIMEOUT itself; the count stops there.
    localparam int CNT_W = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      TIMEOUT_VAL = CNT_W'(WAIT_TIMEOUT);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO    = '0;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0]  wait_cnt_d;

    logic              dmem_req;
    logic              mem_stall;
    logic              err_hold;
    logic              load_use;
    logic              redirect_flush;
    logic              lu_stall;

    // State and wait counter registers with synchronous reset.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state, wait-counter update and memory-side decode for the FSM.
    // NOTE: every signal gets a default before the case statement, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        dmem_req   = 1'b0;
        mem_stall  = 1'b0;
        err_hold   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                // The request follows the access directly; a ready memory
                // completes it in this cycle with no stall.
                dmem_req = bus.mem_access_i;
                if (bus.mem_access_i && !bus.dmem_ready_i) begin
                    mem_stall  = 1'b1;
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                // Request held until the memory answers; the completing cycle
                // is not stalled so EX/MEM can advance.
                dmem_req = 1'b1;
                if (bus.dmem_ready_i) begin
                    state_d = ST_RUN;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt_q == TIMEOUT_VAL) begin
                        state_d = ST_ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ERR: begin
                // Dead until reset: freeze the pipeline, stop requesting.
                err_hold = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Load-use: a load in EX writes a register the ID instruction reads.
    // x0 is never a real dependency.
    assign load_use = bus.ex_valid_i && bus.ex_mem_ren_i
                   && (bus.ex_rd_addr_i != REG_ZERO)
                   && ((bus.id_rs1_used_i && (bus.id_rs1_addr_i == bus.ex_rd_addr_i))
                    || (bus.id_rs2_used_i && (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));

    // Redirect is deferred while memory stalls; it discards the wrong-path
    // instruction in ID, so a load-use stall for it is pointless.
    assign redirect_flush = bus.ex_redirect_i && !mem_stall && !err_hold;
    assign lu_stall       = load_use && !mem_stall && !err_hold && !bus.ex_redirect_i;

    // Drive pipeline controls; everything is forced low while reset is held.
    always_comb begin
        bus.dmem_req_o     = 1'b0;
        bus.pc_stall_o     = 1'b0;
        bus.ifid_stall_o   = 1'b0;
        bus.idex_stall_o   = 1'b0;
        bus.exmem_stall_o  = 1'b0;
        bus.ifid_flush_o   = 1'b0;
        bus.idex_flush_o   = 1'b0;
        bus.memwb_bubble_o = 1'b0;
        bus.bus_err_o      = 1'b0;
        if (!rst_i) begin
            bus.dmem_req_o     = dmem_req;
            // Load-use freezes PC and IF/ID and lets a bubble enter EX.
            bus.pc_stall_o     = err_hold || mem_stall || lu_stall;
            bus.ifid_stall_o   = err_hold || mem_stall || lu_stall;
            // A memory wait freezes everything up to EX/MEM and feeds a
            // bubble into WB so no stale result is written twice.
            bus.idex_stall_o   = err_hold || mem_stall;
            bus.exmem_stall_o  = err_hold || mem_stall;
            bus.memwb_bubble_o = err_hold || mem_stall;
            bus.ifid_flush_o   = redirect_flush;
            bus.idex_flush_o   = redirect_flush || lu_stall;
            bus.bus_err_o      = err_hold;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_lu_q;
    logic [31:0] perf_mem_q;
    logic [31:0] perf_flush_q;

    // Count cycles in which each control action is applied; wraps at 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_lu_q    <= '0;
            perf_mem_q   <= '0;
            perf_flush_q <= '0;
        end else begin
            if (lu_stall)       perf_lu_q    <= perf_lu_q + 32'd1;
            if (mem_stall)      perf_mem_q   <= perf_mem_q + 32'd1;
            if (redirect_flush) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_lu_stall_o  = rst_i ? 32'd0 : perf_lu_q;
    assign perf_mem_stall_o = rst_i ? 32'd0 : perf_mem_q;
    assign perf_flush_o     = rst_i ? 32'd0 : perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Self-checking bench for pipeline_hazard_ctrl (WAIT_TIMEOUT=4). Outputs are
// packed as {dmem_req, pc_stall, ifid_stall, idex_stall, exmem_stall,
// ifid_flush, idex_flush, memwb_bubble, bus_err} and compared each cycle with
// a reference model that tracks "is an access pending, and for how long".
// Define PIPE_PERF_CNT_EN to also check the performance counters.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;
    localparam int TO = 4;

    logic clk_i = 1'b0;
    logic rst_i;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(AW)) bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_lu_stall;
    logic [31:0] perf_mem_stall;
    logic [31:0] perf_flush;
`endif

    pipeline_hazard_ctrl #(
        .REG_ADDR_W   (AW),
        .WAIT_TIMEOUT (TO)
    ) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_lu_stall_o  (perf_lu_stall),
        .perf_mem_stall_o (perf_mem_stall),
        .perf_flush_o     (perf_flush)
`endif
    );

    always #5 clk_i = ~clk_i;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: access pending flag, cycles it has been pending
    // (after the cycle that issued it), and the dead-after-timeout flag.
    bit          m_pending = 1'b0;
    int          m_age     = 0;
    bit          m_dead    = 1'b0;
    logic [31:0] m_perf_lu    = '0;
    logic [31:0] m_perf_mem   = '0;
    logic [31:0] m_perf_flush = '0;

    function automatic logic [8:0] dut_out();
        return {bus.dmem_req_o, bus.pc_stall_o, bus.ifid_stall_o, bus.idex_stall_o,
                bus.exmem_stall_o, bus.ifid_flush_o, bus.idex_flush_o,
                bus.memwb_bubble_o, bus.bus_err_o};
    endfunction

    // Expected outputs from the priority rules applied to current inputs.
    function automatic logic [8:0] model_out();
        bit mem_wait, hazard, rflush, lu;
        if (rst_i) return 9'b0;
        if (m_dead) return {1'b0, 4'b1111, 2'b00, 1'b1, 1'b1};
        mem_wait = !bus.dmem_ready_i && (m_pending || bus.mem_access_i);
        hazard   = bus.ex_valid_i && bus.ex_mem_ren_i && (bus.ex_rd_addr_i != 0) &&
                   ((bus.id_rs1_used_i && bus.id_rs1_addr_i == bus.ex_rd_addr_i) ||
                    (bus.id_rs2_used_i && bus.id_rs2_addr_i == bus.ex_rd_addr_i));
        rflush   = bus.ex_redirect_i && !mem_wait;
        lu       = hazard && !mem_wait && !bus.ex_redirect_i;
        return {m_pending || bus.mem_access_i, mem_wait || lu, mem_wait || lu,
                mem_wait, mem_wait, rflush, rflush || lu, mem_wait, 1'b0};
    endfunction

    // Advance the model across one clock edge (inputs still pre-edge).
    task automatic model_clock();
        logic [8:0] e;
        e = model_out();
        if (rst_i) begin
            m_pending = 1'b0; m_age = 0; m_dead = 1'b0;
            m_perf_lu = '0; m_perf_mem = '0; m_perf_flush = '0;
            return;
        end
        if (m_dead) return;
        if (e[7] && !e[5]) m_perf_lu    = m_perf_lu + 1;
        if (e[5])          m_perf_mem   = m_perf_mem + 1;
        if (e[3])          m_perf_flush = m_perf_flush + 1;
        if (m_pending) begin
            if (bus.dmem_ready_i)  m_pending = 1'b0;
            else if (m_age == TO)  m_dead = 1'b1;
            else                   m_age++;
        end else if (bus.mem_access_i && !bus.dmem_ready_i) begin
            m_pending = 1'b1;
            m_age     = 0;
        end
    endtask

    // One clock: sample at the falling edge, then move past the rising edge.
    task automatic step(output logic [8:0] got, output logic [8:0] exp);
        @(negedge clk_i);
        got = dut_out();
        exp = model_out();
        @(posedge clk_i);
        model_clock();
        #1;
    endtask

    task automatic set_idle();
        bus.id_rs1_addr_i = '0; bus.id_rs2_addr_i = '0;
        bus.id_rs1_used_i = 1'b0; bus.id_rs2_used_i = 1'b0;
        bus.ex_valid_i = 1'b0; bus.ex_mem_ren_i = 1'b0; bus.ex_rd_addr_i = '0;
        bus.ex_redirect_i = 1'b0; bus.mem_access_i = 1'b0; bus.dmem_ready_i = 1'b1;
    endtask

    task automatic set_load_use(input logic [AW-1:0] rd);
        bus.ex_valid_i = 1'b1; bus.ex_mem_ren_i = 1'b1; bus.ex_rd_addr_i = rd;
        bus.id_rs1_addr_i = rd; bus.id_rs1_used_i = 1'b1;
        bus.id_rs2_addr_i = 5'd3; bus.id_rs2_used_i = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] got, exp;
        rst_i = 1'b1;
        bus.mem_access_i = 1'b1; bus.dmem_ready_i = 1'b0; bus.ex_redirect_i = 1'b1;
        set_load_use(5'd7);
        for (int i = 0; i < 2; i++) begin
            step(got, exp);
            tests_run++;
            if (got !== 9'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs_low: got %b required %b", got, 9'b0);
            end
        end
        rst_i = 1'b0; set_idle();
        step(got, exp);
        tests_run++;
        if (got !== exp || got !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got %b required %b", got, exp);
        end
    endtask

    task automatic test_load_use();
        logic [8:0] got, exp;
        set_idle(); set_load_use(5'd5);
        step(got, exp);
        tests_run++;
        if (got !== exp || got !== 9'b011000100) begin
            tests_failed++;
            $display("FAIL load_use_x5: got %b required %b", got, 9'b011000100);
        end
        // The flushed ID/EX register now holds a bubble: no further stall.
        bus.ex_valid_i = 1'b0;
        step(got, exp);
        tests_run++;
        if (got !== exp || got !== 9'b0) begin
            tests_failed++;
            $display("FAIL load_use_one_cycle: got %b required %b", got, 9'b0);
        end
        set_load_use(5'd0);
        step(got, exp);
        tests_run++;
        if (got !== exp || got !== 9'b0) begin
            tests_failed++;
            $display("FAIL load_use_x0: got %b required %b", got, 9'b0);
        end
        // rs2 match only counts when rs2 is used.
        set_load_use(5'd9); bus.id_rs1_addr_i = 5'd1; bus.id_rs2_addr_i = 5'd9;
        bus.id_rs2_used_i = 1'b0;
        step(got, exp);
        tests_run++;
        if (got !== exp || got !== 9'b0) begin
            tests_failed++;
            $display("FAIL load_use_rs2_unused: got %b required %b", got, 9'b0);
        end
        bus.id_rs2_used_i = 1'b1;
        step(got, exp);
        tests_run++;
        if (got !== exp || got !== 9'b011000100) begin
            tests_failed++;
            $display("FAIL load_use_rs2: got %b required %b", got, 9'b011000100);
        end
        set_idle();
    endtask

    task automatic test_mem_wait();
        logic [8:0] got, exp;
        int stalls = 0;
        set_idle(); bus.mem_access_i = 1'b1; bus.dmem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(got, exp);
            tests_run++;
            if (got !== exp || got !== 9'b111110010) begin
                tests_failed++;
                $display("FAIL mem_wait_stall[%0d]: got %b required %b", i, got, 9'b111110010);
            end
            if (got[7] && got[1]) stalls++;
        end
        bus.dmem_ready_i = 1'b1;
        step(got, exp);
        tests_run++;
        if (got !== exp || got !== 9'b100000000) begin
            tests_failed++;
            $display("FAIL mem_wait_done: got %b required %b", got, 9'b100000000);
        end
        tests_run++;
        if (stalls != 3) begin
            tests_failed++;
            $display("FAIL mem_wait_count: got %0d required %0d", stalls, 3);
        end
        // Back in RUN: a ready access completes with zero stall.
        step(got, exp);
        tests_run++;
        if (got !== exp || got !== 9'b100000000) begin
            tests_failed++;
            $display("FAIL mem_ready_zero_stall: got %b required %b", got, 9'b100000000);
        end
        set_idle();
    endtask

    task automatic test_redirect_lu();
        logic [8:0] got, exp;
        set_idle(); set_load_use(5'd12); bus.ex_redirect_i = 1'b1;
        step(got, exp);
        tests_run++;
        if (got !== exp || got !== 9'b000001100) begin
            tests_failed++;
            $display("FAIL redirect_over_load_use: got %b required %b", got, 9'b000001100);
        end
        set_idle();
    endtask

    task automatic test_redirect_wait();
        logic [8:0] got, exp;
        set_idle(); bus.mem_access_i = 1'b1; bus.dmem_ready_i = 1'b0; bus.ex_redirect_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(got, exp);
            tests_run++;
            if (got !== exp || got !== 9'b111110010) begin
                tests_failed++;
                $display("FAIL redirect_deferred[%0d]: got %b required %b", i, got, 9'b111110010);
            end
        end
        // Flush lands in the cycle following the last stall cycle.
        bus.dmem_ready_i = 1'b1;
        step(got, exp);
        tests_run++;
        if (got !== exp || got !== 9'b100001100) begin
            tests_failed++;
            $display("FAIL redirect_released: got %b required %b", got, 9'b100001100);
        end
        set_idle();
    endtask

    task automatic test_reset_mid_wait();
        logic [8:0] got, exp;
        set_idle(); bus.mem_access_i = 1'b1; bus.dmem_ready_i = 1'b0;
        step(got, exp);
        step(got, exp);
        rst_i = 1'b1;
        step(got, exp);
        tests_run++;
        if (got !== exp || got !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: got %b required %b", got, 9'b0);
        end
        rst_i = 1'b0; bus.mem_access_i = 1'b0;
        step(got, exp);
        tests_run++;
        if (got !== exp || got[8] !== 1'b0) begin
            tests_failed++;
            $display("FAIL req_after_reset: got %b required %b", got, exp);
        end
        set_idle();
    endtask

    task automatic test_timeout();
        logic [8:0] got, exp;
        int seen = -1;
        set_idle(); bus.mem_access_i = 1'b1; bus.dmem_ready_i = 1'b0;
        // Issue cycle, then WAIT with the counter at 0..TO; ERR afterwards.
        for (int i = 0; i < 20 && seen < 0; i++) begin
            step(got, exp);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL timeout_seq[%0d]: got %b required %b", i, got, exp);
            end
            if (got[0] === 1'b1) seen = i;
        end
        tests_run++;
        if (seen != TO + 2) begin
            tests_failed++;
            $display("FAIL timeout_cycle: got %0d required %0d", seen, TO + 2);
        end
        for (int i = 0; i < 6; i++) begin
            bus.dmem_ready_i = 1'(i % 2); bus.ex_redirect_i = 1'(i % 3 == 0);
            bus.mem_access_i = 1'($urandom_range(0, 1));
            step(got, exp);
            tests_run++;
            if (got !== exp || got !== 9'b011110011) begin
                tests_failed++;
                $display("FAIL err_sticky[%0d]: got %b required %b", i, got, 9'b011110011);
            end
        end
        rst_i = 1'b1;
        step(got, exp);
        rst_i = 1'b0; set_idle();
        step(got, exp);
        tests_run++;
        if (got !== exp || got !== 9'b0) begin
            tests_failed++;
            $display("FAIL err_cleared: got %b required %b", got, 9'b0);
        end
    endtask

    task automatic test_random();
        logic [8:0] got, exp;
        for (int i = 0; i < 600; i++) begin
            rst_i = ($urandom_range(0, 99) < 3);
            bus.id_rs1_addr_i = AW'($urandom_range(0, 3));
            bus.id_rs2_addr_i = AW'($urandom_range(0, 3));
            bus.id_rs1_used_i = 1'($urandom_range(0, 1));
            bus.id_rs2_used_i = 1'($urandom_range(0, 1));
            bus.ex_valid_i    = ($urandom_range(0, 3) != 0);
            bus.ex_mem_ren_i  = 1'($urandom_range(0, 1));
            bus.ex_rd_addr_i  = AW'($urandom_range(0, 3));
            bus.ex_redirect_i = ($urandom_range(0, 99) < 15);
            bus.mem_access_i  = ($urandom_range(0, 99) < 40);
            bus.dmem_ready_i  = ($urandom_range(0, 99) < 70);
`ifdef PIPE_PERF_CNT_EN
            @(negedge clk_i);
            tests_run++;
            if ({perf_lu_stall, perf_mem_stall, perf_flush} !==
                (rst_i ? 96'b0 : {m_perf_lu, m_perf_mem, m_perf_flush})) begin
                tests_failed++;
                $display("FAIL perf_random[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d", i,
                         perf_lu_stall, perf_mem_stall, perf_flush,
                         m_perf_lu, m_perf_mem, m_perf_flush);
            end
`endif
            step(got, exp);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %b required %b", i, got, exp);
            end
        end
        rst_i = 1'b0; set_idle();
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf();
        logic [8:0] got, exp;
        rst_i = 1'b1; set_idle();
        step(got, exp);
        rst_i = 1'b0;
        bus.mem_access_i = 1'b1; bus.dmem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) step(got, exp);
        bus.dmem_ready_i = 1'b1;
        step(got, exp);
        set_idle();
        @(negedge clk_i);
        tests_run++;
        if (perf_mem_stall !== 32'd3) begin
            tests_failed++;
            $display("FAIL perf_mem_stall: got %0d required %0d", perf_mem_stall, 3);
        end
        rst_i = 1'b1;
        step(got, exp);
        rst_i = 1'b0;
        @(negedge clk_i);
        tests_run++;
        if ({perf_lu_stall, perf_mem_stall, perf_flush} !== 96'b0) begin
            tests_failed++;
            $display("FAIL perf_reset: got %0d/%0d/%0d required 0/0/0",
                     perf_lu_stall, perf_mem_stall, perf_flush);
        end
    endtask
`endif

    initial begin
        rst_i = 1'b1;
        set_idle();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_redirect_lu();
        test_redirect_wait();
        test_reset_mid_wait();
        test_timeout();
        test_random();
`ifdef PIPE_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
